// File: rtl/ft245_cmd_decoder.sv
// FT245 byte-stream command decoder: 3-byte frames (addr, data hi, data lo)
// become register write strobes; bad addresses and stalled frames pulse frame_err.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   rx_data_si      - received byte, valid while rx_rdy_si=1
//   rx_rdy_si       - upstream byte available
//   rx_ack_si       - one-cycle byte-consumed pulse
//   register_addr   - address of the last completed write
//   register_data   - data of the last completed write
//   register_rdy    - one-cycle write strobe
//   frame_err       - one-cycle pulse on a dropped frame
module ft245_cmd_decoder #(
  parameter int FT245_WIDTH    = 8,
  parameter int REG_DATA_WIDTH = 2 * FT245_WIDTH,
  parameter int NUM_REGS       = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [FT245_WIDTH-1:0]    rx_data_si,
  input  logic                      rx_rdy_si,
  output logic                      rx_ack_si,
  output logic [7:0]                register_addr,
  output logic [REG_DATA_WIDTH-1:0] register_data,
  output logic                      register_rdy,
  output logic                      frame_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] T_MAX  = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_HI,
    S_WRITE
  } state_t;

  state_t state, state_n;

  logic [FT245_WIDTH-1:0] addr_q;
  logic [FT245_WIDTH-1:0] hi_q;
  logic [FT245_WIDTH-1:0] lo_q;
  logic [CW-1:0]          cnt;

  logic accept;
  logic timeout;
  logic wr_ok;
  logic wr_bad;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    wr_ok   = 1'b0;
    wr_bad  = 1'b0;
    // No byte while the previous ack is out, during WRITE, or in reset.
    accept  = rx_rdy_si && !rx_ack_si &&
              (state != S_WRITE) && !rst;
    timeout = ((state == S_ADDR) || (state == S_HI)) &&
              (cnt == T_LAST);
    unique case (state)
      S_IDLE: begin
        if (accept) state_n = S_ADDR;
      end
      S_ADDR: begin
        if (accept)       state_n = S_HI;
        else if (timeout) state_n = S_IDLE;
      end
      S_HI: begin
        if (accept)       state_n = S_WRITE;
        else if (timeout) state_n = S_IDLE;
      end
      S_WRITE: begin
        state_n = S_IDLE;
        if (int'(addr_q) < NUM_REGS) wr_ok = 1'b1;
        else                         wr_bad = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Gap counter: a byte arriving in the expiry cycle clears it first.
  always_ff @(posedge clk) begin
    if (rst || accept || (state_n == S_IDLE)) begin
      cnt <= '0;
    end else if ((state == S_ADDR) || (state == S_HI)) begin
      if (cnt != T_MAX) cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else if (accept) begin
      unique case (state)
        S_IDLE:  addr_q <= rx_data_si;
        S_ADDR:  hi_q   <= rx_data_si;
        S_HI:    lo_q   <= rx_data_si;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ack_si     <= 1'b0;
      register_rdy  <= 1'b0;
      frame_err     <= 1'b0;
      register_addr <= '0;
      register_data <= '0;
    end else begin
      rx_ack_si    <= accept;
      register_rdy <= wr_ok;
      frame_err    <= wr_bad || (timeout && !accept);
      if (wr_ok) begin
        register_addr <= 8'(addr_q);
        register_data <= {hi_q, lo_q};
      end
    end
  end

endmodule

// File: doc/ft245_cmd_decoder.md
FT245_CMD_DECODER -- requirements
Module: ft245_cmd_decoder

Interface
REQ-001 The module SHALL have parameter FT245_WIDTH, default 8, giving the byte width of the receive simple interface.
REQ-002 The module SHALL have parameter REG_DATA_WIDTH, default 16, giving the register data width; it is fixed at 2*FT245_WIDTH.
REQ-003 The module SHALL have parameter NUM_REGS, default 16, giving the number of valid register addresses (0..NUM_REGS-1).
REQ-004 The module SHALL have parameter TIMEOUT_CYCLES, default 1000000 (10 ms at 10 ns), giving the maximum gap between bytes inside a frame.
REQ-005 The module SHALL use one clock and a synchronous, active-high reset: clk  input  1  system clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 rx_data_si  input  FT245_WIDTH  received byte; valid while rx_rdy_si=1.
REQ-008 rx_rdy_si  input  1  upstream byte available.
REQ-009 rx_ack_si  output  1  one-cycle byte-consumed pulse to upstream.
REQ-010 register_addr  output  8  address of the last completed write.
REQ-011 register_data  output  REG_DATA_WIDTH  data of the last completed write.
REQ-012 register_rdy  output  1  one-cycle write strobe; addr/data valid in the same cycle.
REQ-013 frame_err  output  1  one-cycle pulse on a dropped frame.

Function
REQ-014 A frame SHALL be 3 bytes in this order: address, data[15:8], data[7:0].
REQ-015 States SHALL be: IDLE (wait for address), ADDR (wait for high byte), HI (wait for low byte), WRITE (one cycle).
REQ-016 A byte SHALL be accepted in a cycle where rx_rdy_si=1 and rx_ack_si=0; the byte is registered on that edge.
REQ-017 The module SHALL drive rx_ack_si=1 for exactly the one cycle after acceptance; no byte is accepted while rx_ack_si=1. Upstream drops rx_rdy_si the cycle after it sees the ack, giving at most one byte per 2 cycles.
REQ-018 Transitions SHALL be: IDLE->ADDR on an accepted byte (latches the address); ADDR->HI on an accepted byte (latches the high byte); HI->WRITE on an accepted byte (latches the low byte); WRITE->IDLE unconditionally.
REQ-019 In WRITE, if the address < NUM_REGS, the module SHALL update register_addr/register_data and pulse register_rdy=1 for one cycle, 1 cycle after the low-byte ack cycle.
REQ-020 In WRITE, if the address >= NUM_REGS, the module SHALL leave register_addr/register_data unchanged, keep register_rdy=0, and pulse frame_err=1.
REQ-021 The timeout counter SHALL clear on every accepted byte and on entry to IDLE, and SHALL increment each cycle in ADDR or HI.
REQ-022 When the counter reaches TIMEOUT_CYCLES-1 in ADDR or HI, the module SHALL discard the partial frame, pulse frame_err, and return to IDLE on the next edge.
REQ-023 If a byte is accepted in the same cycle the timeout would fire, the byte SHALL win: it advances the state, the counter clears, and no frame_err is raised.
REQ-024 The module SHALL not accept a byte in WRITE; a byte pending during WRITE is accepted in IDLE as the next address.
REQ-025 register_rdy and frame_err SHALL never both be 1 in the same cycle.
REQ-026 The counter SHALL be wide enough to hold TIMEOUT_CYCLES and SHALL saturate rather than wrap.

Reset
REQ-027 While rst=1, the module SHALL set state=IDLE, rx_ack_si=0, register_rdy=0, frame_err=0, register_addr=0, register_data=0, timeout counter=0, and all internal byte latches=0.
REQ-028 A reset asserted mid-frame SHALL discard the partial frame with no register_rdy and no frame_err pulse; the first byte accepted after reset is treated as an address.
REQ-029 The module SHALL accept no byte in the cycle rst=1.

Verification
REQ-030 Bytes 0x03, 0x12, 0x34 sent with rx_rdy_si held until ack -> three 1-cycle ack pulses; register_rdy=1 once with register_addr=0x03 and register_data=0x1234; frame_err stays 0.
REQ-031 Bytes 0x10, 0xAB, 0xCD with NUM_REGS=16 -> frame_err pulses once; register_rdy=0; register_addr/register_data keep their previous values.
REQ-032 With TIMEOUT_CYCLES=20: send 0x05, 0x11, then silence -> frame_err pulses 20 cycles after the last ack; then 0x02, 0x00, 0x07 -> register_rdy with addr 0x02 and data 0x0007.
REQ-033 Send 0x01, 0x22, assert rst for 1 cycle, then send 0x04, 0x55, 0x66 -> no strobe and no error from the first frame; one strobe with addr 0x04 and data 0x5566.
REQ-034 With TIMEOUT_CYCLES=20, present the second byte exactly in the expiry cycle -> byte accepted, frame_err stays 0, and the frame completes normally.
REQ-035 Back-to-back frames with rx_rdy_si reasserted immediately after each drop -> one byte accepted per 2 cycles; each frame strobes with correct addr/data; no byte is lost or duplicated.
